// File: rtl/sram_l1_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_l1_pkg                                                                |
// | Shared types and default sizes for the two-port L1 SRAM arbiter.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sram_l1_pkg;

   localparam int ADDR_WIDTH_DEF   = 9;
   localparam int DATA_WIDTH_DEF   = 33;   // wrapper parameter; payload is one bit narrower
   localparam int NUM_WMASKS_DEF   = 4;
   localparam int WRITE_HOLD_DEF   = 2;
   localparam int READ_TIMEOUT_DEF = 80;
   localparam int CNT_W            = 8;    // wait counter, saturating, covers timeouts up to 255

   // Access sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   // Latched request; field widths follow the package defaults above
   typedef struct packed {
      logic                        wr;
      logic [ADDR_WIDTH_DEF-1:0]   addr;
      logic [DATA_WIDTH_DEF-2:0]   wdata;
      logic [NUM_WMASKS_DEF-1:0]   wmask;
   } req_t;

endpackage : sram_l1_pkg
`default_nettype wire

// File: rtl/sram_l1_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                    |
// | Two-way round-robin arbiter. On a tie the port not granted last wins;      |
// | the history register only moves when a grant is actually accepted.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   logic last_grant_q;
   logic last_grant_d;

   // History register: resets to port 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   // Grant selection and history update on accept
   always_comb begin
      grant_o      = 2'b00;
      last_grant_d = last_grant_q;
      unique case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
      if (accept_i) begin
         last_grant_d = grant_o[1];
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_l1_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_l1_arbiter                                                            |
// | Two-port arbiter and access sequencer in front of sram_wrap_l1. Grants     |
// | fetch / load-store requests round-robin and drives the wrapper's          |
// | active-low csb/we with setup, hold and release cycles.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_l1_arbiter
   import sram_l1_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int NUM_WMASKS   = NUM_WMASKS_DEF,
   parameter int WRITE_HOLD   = WRITE_HOLD_DEF,
   parameter int READ_TIMEOUT = READ_TIMEOUT_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [1:0]                        req_valid_i,
   output logic [1:0]                        req_ready_o,
   input  logic [1:0]                        req_wr_i,
   input  logic [1:0][ADDR_WIDTH-1:0]        req_addr_i,
   input  logic [1:0][DATA_WIDTH-2:0]        req_wdata_i,
   input  logic [1:0][NUM_WMASKS-1:0]        req_wmask_i,
   output logic [1:0]                        resp_valid_o,
   output logic [1:0][DATA_WIDTH-2:0]        resp_rdata_o,
   output logic [1:0]                        resp_err_o,
   output logic [ADDR_WIDTH-1:0]             sram_addr_o,
   output logic [DATA_WIDTH-2:0]             sram_data_in_o,
   output logic [NUM_WMASKS-1:0]             sram_wmask_o,
   output logic                              sram_we_o,
   output logic                              sram_csb_o,
   input  logic [DATA_WIDTH-2:0]             sram_data_out_i,
   input  logic                              sram_data_ready_i
);

   state_e                 state_q, state_d;
   req_t                   req_q, req_d;
   logic                   owner_q, owner_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-2:0]  rdata_q, rdata_d;

   logic [1:0]             grant;
   logic [1:0]             ready;
   logic                   accept;
   logic                   sel;

   // Only IDLE offers a grant, so at most one transaction is ever in flight
   assign ready       = grant & {2{state_q == ST_IDLE}};
   assign accept      = |(req_valid_i & ready);
   assign sel         = grant[1];
   assign req_ready_o = ready;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (req_valid_i),
      .accept_i (accept),
      .grant_o  (grant)
   );

   // State and transaction registers; reset drops any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state: latch on accept, count hold / wait cycles in ACCESS
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               owner_d     = sel;
               req_d.wr    = req_wr_i[sel];
               req_d.addr  = req_addr_i[sel];
               req_d.wdata = req_wdata_i[sel];
               req_d.wmask = req_wmask_i[sel];
               err_d       = 1'b0;
               cnt_d       = '0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (req_q.wr) begin
               if (cnt_q == CNT_W'(WRITE_HOLD - 1)) begin
                  state_d = ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (sram_data_ready_i) begin
               rdata_d = sram_data_out_i;
               state_d = ST_RELEASE;
            end else if (cnt_q == CNT_W'(READ_TIMEOUT)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RELEASE;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs: wrapper strobes decoded from state, address/data from the latch
   always_comb begin
      sram_addr_o    = req_q.addr;
      sram_data_in_o = req_q.wdata;
      sram_wmask_o   = req_q.wmask;
      sram_csb_o     = 1'b1;
      sram_we_o      = 1'b1;
      resp_valid_o   = 2'b00;
      resp_err_o     = 2'b00;
      resp_rdata_o   = {2{rdata_q}};
      unique case (state_q)
         ST_SETUP:   sram_we_o = ~req_q.wr;
         ST_ACCESS: begin
            sram_csb_o = 1'b0;
            sram_we_o  = ~req_q.wr;
         end
         ST_RELEASE: sram_we_o = ~req_q.wr;   // we outlives csb by one cycle for hold
         ST_RESP: begin
            resp_valid_o = owner_q ? 2'b10 : 2'b01;
            resp_err_o   = owner_q ? {err_q, 1'b0} : {1'b0, err_q};
         end
         default: ;
      endcase
   end

endmodule : sram_l1_arbiter
`default_nettype wire

// File: tb/tb_sram_l1_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sram_l1_arbiter                                                         |
// | Self-checking bench: behavioural wrapper model with 6-cycle read latency,  |
// | table-driven single-port traffic plus tie, timeout and reset sequences.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_l1_arbiter;

   localparam int AW = 9;
   localparam int PW = 32;
   localparam int MW = 4;
   localparam int WH = 2;
   localparam int RT = 80;

   logic                clk;
   logic                rst_n;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_wr;
   logic [1:0][AW-1:0]  req_addr;
   logic [1:0][PW-1:0]  req_wdata;
   logic [1:0][MW-1:0]  req_wmask;
   logic [1:0]          resp_valid;
   logic [1:0][PW-1:0]  resp_rdata;
   logic [1:0]          resp_err;
   logic [AW-1:0]       sram_addr;
   logic [PW-1:0]       sram_data_in;
   logic [MW-1:0]       sram_wmask;
   logic                sram_we;
   logic                sram_csb;
   logic [PW-1:0]       sram_data_out;
   logic                sram_data_ready;

   sram_l1_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_wr_i          (req_wr),
      .req_addr_i        (req_addr),
      .req_wdata_i       (req_wdata),
      .req_wmask_i       (req_wmask),
      .resp_valid_o      (resp_valid),
      .resp_rdata_o      (resp_rdata),
      .resp_err_o        (resp_err),
      .sram_addr_o       (sram_addr),
      .sram_data_in_o    (sram_data_in),
      .sram_wmask_o      (sram_wmask),
      .sram_we_o         (sram_we),
      .sram_csb_o        (sram_csb),
      .sram_data_out_i   (sram_data_out),
      .sram_data_ready_i (sram_data_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- wrapper model ----------------
   logic [PW-1:0] mem [0:(1<<AW)-1];
   logic [6:0]    rd_cnt = '0;
   logic          force_nodr = 1'b0;

   always @(posedge clk) begin
      if (!sram_csb && !sram_we) begin
         for (int b = 0; b < MW; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_data_in[8*b +: 8];
      end
      if (sram_csb) rd_cnt <= '0;
      else if (sram_we && rd_cnt != 7'h7f) rd_cnt <= rd_cnt + 1'b1;
   end
   assign sram_data_ready = !force_nodr && !sram_csb && sram_we && (rd_cnt == 7'd6);
   assign sram_data_out   = mem[sram_addr];

   // ---------------- checking ----------------
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          port;
      logic        wr;
      logic [PW-1:0] rdata;
      logic        err;
      int          cyc;
      int          csb_base;
      int          we_base;
      int          exp_csb;
      int          exp_we;
   } sb_t;

   logic [PW-1:0] ref_mem [0:(1<<AW)-1];
   logic [PW-1:0] p_exp [2];
   int            last_model = 1;

   task automatic issue(input logic [1:0] mask);
      logic [1:0] pending;
      sb_t        q[$];
      sb_t        e;
      int         csb_tot;
      int         we_tot;
      int         guard;
      logic [1:0] exp_oh;
      pending = mask;
      csb_tot = 0;
      we_tot  = 0;
      guard   = 0;
      @(posedge clk); #1;
      req_valid = mask;
      while ((pending != 2'b00 || q.size() != 0) && guard < 400) begin
         @(negedge clk);
         guard++;
         if (!sram_csb) csb_tot++;
         if (!sram_csb && !sram_we) we_tot++;
         for (int p = 0; p < 2; p++) begin
            if (resp_valid[p]) begin
               if (q.size() == 0 || q[0].port != p) begin
                  chk($sformatf("unexpected_resp_p%0d", p), 64'(resp_valid), 64'd0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("resp_cycle_p%0d", p), 64'(cyc), 64'(e.cyc));
                  chk($sformatf("resp_err_p%0d", p), 64'(resp_err[p]), 64'(e.err));
                  if (!e.wr) chk($sformatf("resp_rdata_p%0d", p), 64'(resp_rdata[p]), 64'(e.rdata));
                  chk($sformatf("csb_low_cycles_p%0d", p), 64'(csb_tot - e.csb_base), 64'(e.exp_csb));
                  chk($sformatf("we_low_cycles_p%0d", p), 64'(we_tot - e.we_base), 64'(e.exp_we));
               end
            end
         end
         if (|(req_ready & ~pending))
            chk("ready_for_idle_port", 64'(req_ready), 64'(req_ready & pending));
         for (int p = 0; p < 2; p++) begin
            if (pending[p] && req_ready[p]) begin
               if (pending == 2'b11) begin
                  exp_oh = (last_model == 1) ? 2'b01 : 2'b10;
                  chk("tie_grant", 64'(req_ready), 64'(exp_oh));
               end
               last_model = p;
               pending[p] = 1'b0;
               e.port     = p;
               e.wr       = req_wr[p];
               e.err      = !req_wr[p] && force_nodr;
               e.rdata    = e.err ? '0 : p_exp[p];
               e.cyc      = cyc + (req_wr[p] ? 3 + WH : (force_nodr ? 4 + RT : 10));
               e.csb_base = csb_tot;
               e.we_base  = we_tot;
               e.exp_csb  = req_wr[p] ? WH : (force_nodr ? RT + 1 : 7);
               e.exp_we   = req_wr[p] ? WH : 0;
               q.push_back(e);
               if (req_wr[p])
                  for (int b = 0; b < MW; b++)
                     if (req_wmask[p][b]) ref_mem[req_addr[p]][8*b +: 8] = req_wdata[p][8*b +: 8];
               @(posedge clk); #1;
               req_valid = pending;
            end
         end
      end
      if (guard >= 400) chk("issue_bound_expired", 64'(guard), 64'd0);
      req_valid = 2'b00;
   endtask

   task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a,
                           input logic [PW-1:0] d, input logic [MW-1:0] m, input logic [PW-1:0] x);
      req_wr[p]    = wr;
      req_addr[p]  = a;
      req_wdata[p] = d;
      req_wmask[p] = m;
      p_exp[p]     = x;
   endtask

   typedef struct {
      int            port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [PW-1:0] wdata;
      logic [MW-1:0] wmask;
      logic [PW-1:0] exp_rdata;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int guard;
      int seen;
      for (int i = 0; i < (1<<AW); i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      tbl[0] = '{0, 1'b1, 9'd48, 32'd77,         4'b1111, 32'd0};
      tbl[1] = '{1, 1'b1, 9'd49, 32'd1,          4'b1111, 32'd0};
      tbl[2] = '{0, 1'b0, 9'd48, 32'd0,          4'b0000, 32'd77};
      tbl[3] = '{1, 1'b1, 9'd5,  32'hAABBCCDD,   4'b1111, 32'd0};
      tbl[4] = '{0, 1'b1, 9'd5,  32'h11223344,   4'b0101, 32'd0};
      tbl[5] = '{1, 1'b0, 9'd5,  32'd0,          4'b0000, 32'hAA22CC44};
      tbl[6] = '{1, 1'b0, 9'd49, 32'd0,          4'b0000, 32'd1};
      tbl[7] = '{0, 1'b1, 9'd48, 32'hFFFFFFFF,   4'b0000, 32'd0};
      tbl[8] = '{0, 1'b0, 9'd48, 32'd0,          4'b0000, 32'd77};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_csb", 64'(sram_csb), 64'd1);
      chk("rst_we", 64'(sram_we), 64'd1);
      chk("rst_addr", 64'(sram_addr), 64'd0);
      chk("rst_data_in", 64'(sram_data_in), 64'd0);
      chk("rst_wmask", 64'(sram_wmask), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single-port traffic
      for (int i = 0; i < 9; i++) begin
         set_port(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].exp_rdata);
         issue(2'b01 << tbl[i].port);
      end

      // read timeout, then a normal request is still served
      force_nodr = 1'b1;
      set_port(1, 1'b0, 9'd48, '0, '0, '0);
      issue(2'b10);
      force_nodr = 1'b0;
      set_port(0, 1'b0, 9'd49, '0, '0, ref_mem[49]);
      issue(2'b01);

      // asynchronous reset in the middle of a write access
      set_port(0, 1'b1, 9'd100, 32'hDEADBEEF, 4'b1111, '0);
      @(posedge clk); #1;
      req_valid = 2'b01;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!req_ready[0] && guard < 20);
      if (guard >= 20) chk("rst_seq_accept_bound", 64'(guard), 64'd0);
      @(posedge clk); #1;
      req_valid = 2'b00;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (sram_csb && guard < 20);
      chk("rst_seq_we_low_before_reset", 64'(sram_we), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_csb", 64'(sram_csb), 64'd1);
      chk("async_rst_we", 64'(sram_we), 64'd1);
      chk("async_rst_addr", 64'(sram_addr), 64'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid != 2'b00) seen++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_model = 1;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid != 2'b00) seen++;
      end
      chk("no_resp_after_reset", 64'(seen), 64'd0);

      // post-reset reads: old data intact, aborted write never landed
      set_port(1, 1'b0, 9'd48, '0, '0, ref_mem[48]);
      issue(2'b10);
      set_port(1, 1'b0, 9'd100, '0, '0, ref_mem[100]);
      issue(2'b10);

      // simultaneous requests, twice
      set_port(0, 1'b1, 9'd200, 32'h12345678, 4'b1111, '0);
      set_port(1, 1'b1, 9'd201, 32'h9ABCDEF0, 4'b1111, '0);
      issue(2'b11);
      set_port(0, 1'b0, 9'd200, '0, '0, ref_mem[200]);
      set_port(1, 1'b0, 9'd201, '0, '0, ref_mem[201]);
      issue(2'b11);

      @(negedge clk);
      chk("final_csb_idle", 64'(sram_csb), 64'd1);
      chk("final_we_idle", 64'(sram_we), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_sram_l1_arbiter
`default_nettype wire

// File: doc/sram_l1_arbiter.md
# sram_l1_arbiter

Two-port arbiter and access sequencer in front of `sram_wrap_l1`. Accepts read/write requests from two requesters (port 0: fetch, port 1: load/store) over valid/ready handshakes, grants them round-robin, and drives the SRAM wrapper's active-low `csb`/`we` protocol with correct setup, hold and release cycles. Returns read data, or write completion, as a one-cycle response pulse, with a timeout if `data_ready` never arrives.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: SRAM word address width.
- `DATA_WIDTH`, 33: SRAM wrapper data parameter; payload width is `DATA_WIDTH-1` (32).
- `NUM_WMASKS`, 4: byte write-mask width.
- `WRITE_HOLD`, 2: cycles `csb` is held low for a write.
- `READ_TIMEOUT`, 80: maximum cycles waiting for `data_ready`.

Ports (clock and reset are fixed: one clock `clk`; asynchronous, active-low reset `rst_n`):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid[i]`  in  1  request from port i (i = 0, 1)
- `req_ready[i]`  out  1  request accepted this cycle
- `req_wr[i]`  in  1  1 = write, 0 = read (active high)
- `req_addr[i]`  in  ADDR_WIDTH  word address
- `req_wdata[i]`  in  DATA_WIDTH-1  write data
- `req_wmask[i]`  in  NUM_WMASKS  byte mask
- `resp_valid[i]`  out  1  one-cycle completion pulse
- `resp_rdata[i]`  out  DATA_WIDTH-1  read data, valid with `resp_valid`
- `resp_err[i]`  out  1  read timed out, valid with `resp_valid`
- `sram_addr`  out  ADDR_WIDTH  to wrapper `addr`
- `sram_data_in`  out  DATA_WIDTH-1  to wrapper `data_in`
- `sram_wmask`  out  NUM_WMASKS  to wrapper `wmask`
- `sram_we`  out  1  active-low write enable
- `sram_csb`  out  1  active-low chip select
- `sram_data_out`  in  DATA_WIDTH-1  from wrapper
- `sram_data_ready`  in  1  from wrapper

## Operation
- FSM states: IDLE, SETUP, ACCESS, RELEASE, RESP.
- IDLE: arbitrate. If exactly one port is valid, grant it. If both are valid, grant the port not granted last (`last_grant` resets to 1, so port 0 wins the first tie). `req_ready` goes high for the granted port only. The request is latched on `valid && ready`, then the FSM moves to SETUP.
- SETUP: drive `sram_addr`, `sram_data_in` and `sram_wmask` from the latch; `sram_we` = `~wr`; `sram_csb` = 1. Move to ACCESS.
- ACCESS, write: `csb` = 0 for exactly `WRITE_HOLD` cycles, then RELEASE.
- ACCESS, read: `csb` = 0 and `we` = 1. Stay until `sram_data_ready` is sampled 1; capture `sram_data_out` on that edge and go to RELEASE. If the wait counter reaches `READ_TIMEOUT` first, set `err`, capture 0, and go to RELEASE.
- RELEASE: `csb` = 1; `we` holds its value for one cycle; address and data stay stable. Move to RESP.
- RESP: pulse `resp_valid` for the owner; `sram_we` returns to 1. Move to IDLE.
- Responses have no backpressure. Only one transaction is in flight; the other port stalls with `req_ready` = 0.
- Reset (asynchronous, any state): FSM goes to IDLE; `sram_csb` = 1, `sram_we` = 1; `sram_addr`, `sram_data_in`, `sram_wmask` = 0; all `req_ready`, `resp_valid`, `resp_err` = 0; `resp_rdata` = 0; wait counter = 0. An in-flight request is dropped with no response.

## Timing
- Accept at edge T, SETUP at T+1, ACCESS starts at T+2.
- Write: `resp_valid` at T+3+`WRITE_HOLD`, i.e. T+5 by default.
- Read: if `data_ready` is sampled at edge R, `resp_valid` at R+2. With the wrapper's 6-cycle latency, `resp_valid` at T+10.
- Timeout: `resp_valid` with `resp_err` at T+2+`READ_TIMEOUT`+2.
- `req_ready` is combinational from state == IDLE and the arbiter result. No back-to-back grants: minimum 1 IDLE cycle between transactions.
- `sram_data_ready` is ignored outside ACCESS-read. The wait counter saturates and is 8 bits wide, sized for `READ_TIMEOUT` ≤ 255.

## Structure
- Package `sram_l1_pkg`: FSM state enum, default width constants, request struct (`wr`, `addr`, `wdata`, `wmask`).
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a `last_grant` register updated on accept. All other logic is a single FSM module.

## Test plan
- Port 0 writes 77 to addr 48 with mask `1111` → `csb` low exactly 2 cycles with `we` = 0; `resp_valid[0]` at T+5; `resp_err` = 0.
- Port 1 writes 1 to addr 49; port 0 then reads addr 48 → `resp_rdata[0]` = 77 at T+10; `sram_we` = 1 throughout the read.
- Both ports assert valid in the same cycle, repeated twice → grants 0, 1, 0, 1; the loser holds its request and keeps `req_ready` = 0 until granted.
- Read with `sram_data_ready` forced 0 → `resp_valid` and `resp_err` = 1 at T+84; `resp_rdata` = 0; the arbiter then accepts the next request.
- Assert `rst_n` = 0 mid-ACCESS of a write → `csb` and `we` go to 1 asynchronously; no `resp_valid`; a post-reset read returns correctly.
